proc_run_ctrl: RTL and testbench
================================

Name: proc_run_ctrl

Overview:
- Execution controller for the programmable processor: generates the single-cycle clock enable (ProcEn) that advances the processor's control FSM.
- Modes: single FSM-cycle step, single whole-instruction step, and free-run at a divided rate.
- Optional PC breakpoint.
- Sits between the KeyFilter pulse outputs and the Processor; the processor runs on Clk gated by ProcEn.
- CtrlState and EnCount feed the display mux.

Parameters:
- PC_W, 7, width of PC_In and BreakAddr.
- ST_W, 4, width of ProcState.
- FETCH_STATE, 4'h1, processor FSM encoding that marks an instruction boundary.
- RUN_DIV, 25_000_000, Clk cycles between enables in RUN (must be >= 2).

Ports:
- Clk  in  1  system clock (CLOCK_50 domain)
- Reset  in  1  asynchronous, active-low reset
- StepPulse  in  1  one-cycle pulse, already synced and filtered
- RunToggle  in  1  one-cycle pulse, already synced and filtered
- StepMode  in  1  0 = step one FSM cycle; 1 = step one instruction
- ProcState  in  ST_W  processor FSM current state
- PC_In  in  PC_W  processor program counter
- BreakAddr  in  PC_W  breakpoint address
- BreakArm  in  1  1 = breakpoint active
- ProcEn  out  1  registered one-cycle enable to the processor
- Running  out  1  1 in RUN, I_EN, I_CHK
- Halted  out  1  1 in BRK
- CtrlState  out  3  current controller state encoding
- EnCount  out  16  number of ProcEn pulses issued, wraps

Behaviour:
- Reset (Reset=0, async): state IDLE, ProcEn=0, EnCount=0, divider=0, Running=0, Halted=0.
- State encodings: IDLE=0, I_EN=1, I_CHK=2, RUN=3, BRK=4.
- ProcEn is registered: asserted exactly one Clk cycle, in the cycle after the decision.
  - ProcState is sampled no earlier than the cycle after a ProcEn pulse.
- EnCount increments in the same cycle ProcEn=1; FFFF wraps to 0000.
- IDLE:
  - RunToggle -> RUN; divider loads RUN_DIV-1.
  - StepPulse with StepMode=0 -> one ProcEn; stay IDLE.
  - StepPulse with StepMode=1 -> I_EN.
  - RunToggle and StepPulse in the same cycle: RunToggle wins, StepPulse is discarded.
- I_EN: issue ProcEn; -> I_CHK.
- I_CHK (one cycle after the pulse):
  - ProcState != FETCH_STATE -> I_EN.
  - ProcState == FETCH_STATE -> IDLE, or BRK if the breakpoint hits.
  - Pulses are ignored in I_EN and I_CHK, except that RunToggle aborts to IDLE at the next state boundary without issuing a further enable.
- RUN:
  - Divider counts down; at 0, issue ProcEn and reload RUN_DIV-1.
  - RunToggle -> IDLE; divider is cleared, and a pending terminal-count enable in that same cycle is suppressed.
  - StepPulse is ignored.
- Breakpoint hit:
  - Condition: BreakArm=1, ProcState==FETCH_STATE and PC_In==BreakAddr.
  - Evaluated only in I_CHK, and in RUN on the cycle after a ProcEn.
  - On a hit: -> BRK, with no further ProcEn.
  - A hit is never evaluated before the first enable after a resume, so resuming from a break location always advances.
- BRK: Halted=1.
  - RunToggle -> RUN.
  - StepPulse -> IDLE, then handled per StepMode on later pulses (the acknowledging pulse itself issues no enable).
- Reset asserted mid-instruction or mid-run: immediate return to the reset values; processor state is not rewound.

Optional Feature:
- Macro: PROC_BREAKPOINT_EN.
- Defined: breakpoint logic and BRK state exist as above.
- Undefined:
  - BreakAddr and BreakArm are ignored.
  - BRK is unreachable; Halted is tied to 0.
  - I_CHK with FETCH_STATE always -> IDLE; RUN never halts on its own.

Decomposition:
- Package proc_ctrl_pkg holds:
  - enum ctrl_state_t (IDLE..BRK, 3 bits);
  - localparams for FETCH_STATE and the default RUN_DIV;
  - a shared pc_t typedef (logic [6:0]).
- One sub-module, rate_div: down-counter with load, enable and terminal-count output, instantiated for RUN timing.
- FSM, EnCount and breakpoint compare stay in proc_run_ctrl.

Test Plan:
- Step a FSM cycle:
  - Stimulus: reset; StepMode=0; 3 StepPulses spaced 5 cycles apart.
  - Required: 3 one-cycle ProcEn pulses, each 1 cycle after its pulse; EnCount=3; CtrlState stays 0.
- Step an instruction:
  - Stimulus: StepMode=1; processor model takes 4 FSM cycles per instruction from FETCH_STATE=1; one StepPulse.
  - Required: exactly 4 ProcEn pulses, spaced 2 cycles apart; then IDLE; Running is high during the sequence.
- Free-run:
  - Stimulus: RUN_DIV=4; RunToggle.
  - Required: ProcEn every 4th cycle; a second RunToggle landing on a terminal-count cycle produces no enable; IDLE, EnCount frozen.
- Breakpoint:
  - Stimulus: PROC_BREAKPOINT_EN defined; BreakAddr=7'h05, BreakArm=1; run.
  - Required: BRK when PC=05 and ProcState=1; Halted=1; no further ProcEn.
  - Then RunToggle resumes: the first enable is issued, and no re-halt occurs at PC 05.
- Simultaneous pulses:
  - Stimulus: StepPulse and RunToggle in the same cycle while IDLE.
  - Required: RUN entered; no step enable issued.
- Async reset:
  - Stimulus: Reset=0 in the middle of an I_EN/I_CHK sequence.
  - Required: same cycle, ProcEn=0, EnCount=0, CtrlState=0, Running=0, with no dependence on Clk.

Source files
------------

// File: rtl/proc_ctrl_pkg.sv
// proc_ctrl_pkg: shared states, defaults and types for the processor run controller
package proc_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    I_EN  = 3'd1,
    I_CHK = 3'd2,
    RUN   = 3'd3,
    BRK   = 3'd4
  } ctrl_state_t;
  localparam logic [3:0] DEF_FETCH_STATE = 4'h1;
  localparam int         DEF_RUN_DIV     = 25_000_000;
  typedef logic [6:0] pc_t;
endpackage

// File: rtl/proc_run_ctrl_rate_div.sv
// rate_div: loadable down-counter with terminal count, auto-reloads to N-1 while enabled
module rate_div
  import proc_ctrl_pkg::*;
#(
  parameter int N = DEF_RUN_DIV
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);
  localparam int W = $clog2(N);
  localparam logic [W-1:0] TOP = W'(N - 1);
  logic [W-1:0] r_cnt;
  // clear wins over load; reload on terminal count keeps the period at exactly N
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_load || (i_en && o_tc)) r_cnt <= TOP;
    else if (i_en) r_cnt <= r_cnt - 1'b1;
  assign o_tc = r_cnt == '0;
endmodule

// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl: step/instruction-step/free-run enable generator for the processor; PROC_BREAKPOINT_EN adds a PC breakpoint
module proc_run_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int                PC_W        = 7,
  parameter int                ST_W        = 4,
  parameter logic [ST_W-1:0]   FETCH_STATE = ST_W'(DEF_FETCH_STATE),
  parameter int                RUN_DIV     = DEF_RUN_DIV
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            StepPulse,
  input  logic            RunToggle,
  input  logic            StepMode,
  input  logic [ST_W-1:0] ProcState,
  input  logic [PC_W-1:0] PC_In,
  input  logic [PC_W-1:0] BreakAddr,
  input  logic            BreakArm,
  output logic            ProcEn,
  output logic            Running,
  output logic            Halted,
  output logic [2:0]      CtrlState,
  output logic [15:0]     EnCount
);
  ctrl_state_t r_state, w_next;
  logic r_en, r_chk, r_abort, w_en, w_load, w_clr, w_tc, w_hit, w_fetch;
  logic [15:0] r_cnt;
  assign w_fetch = ProcState == FETCH_STATE;
`ifdef PROC_BREAKPOINT_EN
  assign w_hit  = BreakArm && w_fetch && (PC_In == BreakAddr);
  assign Halted = r_state == BRK;
`else
  logic w_unused;
  assign w_unused = ^{BreakArm, BreakAddr, PC_In};
  assign w_hit  = 1'b0;
  assign Halted = 1'b0;
`endif
  rate_div #(.N(RUN_DIV)) u_div (
    .i_clk  (Clk),
    .i_rst_n(Reset),
    .i_clr  (w_clr),
    .i_load (w_load),
    .i_en   (r_state == RUN),
    .o_tc   (w_tc)
  );
  // next state and enable decision; the enable is registered so it lands one cycle later
  always_comb begin
    w_next = r_state;
    w_en   = 1'b0;
    w_load = 1'b0;
    w_clr  = 1'b0;
    case (r_state)
      IDLE: begin
        if (RunToggle) begin
          w_next = RUN;
          w_load = 1'b1;
        end else if (StepPulse) begin
          w_en   = 1'b1;
          w_next = StepMode ? I_EN : IDLE;
        end
      end
      I_EN: w_next = I_CHK;
      I_CHK: begin
        if (r_abort || RunToggle) w_next = IDLE;
        else if (!w_fetch) begin
          w_next = I_EN;
          w_en   = 1'b1;
        end else w_next = w_hit ? BRK : IDLE;
      end
      RUN: begin
        if (RunToggle) begin
          w_next = IDLE;
          w_clr  = 1'b1;
        end else if (r_chk && w_hit) begin
          w_next = BRK;
          w_clr  = 1'b1;
        end else w_en = w_tc;
      end
      BRK: begin
        if (RunToggle) begin
          w_next = RUN;
          w_load = 1'b1;
        end else if (StepPulse) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  // state, enable pulse, post-enable check flag, abort latch and enable counter
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      r_state <= IDLE;
      r_en    <= 1'b0;
      r_chk   <= 1'b0;
      r_abort <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_en    <= w_en;
      r_chk   <= r_en;
      r_abort <= (r_state == I_EN) && RunToggle;
      r_cnt   <= r_cnt + 16'(w_en);
    end
  assign ProcEn    = r_en;
  assign Running   = r_state inside {RUN, I_EN, I_CHK};
  assign CtrlState = r_state;
  assign EnCount   = r_cnt;
endmodule

// File: tb/tb_proc_run_ctrl.sv
// tb_proc_run_ctrl: directed checks of step, instruction step, run, breakpoint and async reset
module tb_proc_run_ctrl;
  logic        Clk = 1'b0, Reset = 1'b0, StepPulse = 1'b0, RunToggle = 1'b0, StepMode = 1'b0, BreakArm = 1'b0;
  logic [3:0]  ProcState = 4'h1;
  logic [6:0]  PC_In = 7'h0, BreakAddr = 7'h0;
  logic        ProcEn, Running, Halted;
  logic [2:0]  CtrlState;
  logic [15:0] EnCount;
  logic        m_init = 1'b0;
  logic [6:0]  m_pc0 = 7'h0;
  int checks = 0, errors = 0;

  always #5 Clk = ~Clk;

  // processor model: 4 FSM states per instruction (1..4), PC advances when wrapping back to fetch
  always @(posedge Clk)
    if (m_init) begin
      ProcState <= 4'h1;
      PC_In     <= m_pc0;
    end else if (ProcEn) begin
      ProcState <= (ProcState == 4'h4) ? 4'h1 : ProcState + 4'h1;
      if (ProcState == 4'h4) PC_In <= PC_In + 7'h1;
    end

  proc_run_ctrl #(.RUN_DIV(4)) dut (
    .Clk(Clk), .Reset(Reset), .StepPulse(StepPulse), .RunToggle(RunToggle), .StepMode(StepMode),
    .ProcState(ProcState), .PC_In(PC_In), .BreakAddr(BreakAddr), .BreakArm(BreakArm),
    .ProcEn(ProcEn), .Running(Running), .Halted(Halted), .CtrlState(CtrlState), .EnCount(EnCount)
  );

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic model_init(input logic [6:0] pc);
    m_pc0 = pc;
    m_init = 1'b1;
    tick();
    m_init = 1'b0;
  endtask

  task automatic test_reset;
    tick(); tick();
    checks++; if (ProcEn !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", ProcEn); end
    checks++; if (EnCount !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0000", EnCount); end
    checks++; if (CtrlState !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", CtrlState); end
    checks++; if (Running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", Running); end
    checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", Halted); end
    model_init(7'h0);
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_step_cycle;
    StepMode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      StepPulse = 1'b1;
      tick();
      StepPulse = 1'b0;
      checks++; if (ProcEn !== 1'b1) begin errors++; $display("FAIL step_en[%0d]: got %b want 1", k, ProcEn); end
      checks++; if (EnCount !== 16'(k + 1)) begin errors++; $display("FAIL step_cnt[%0d]: got %0d want %0d", k, EnCount, k + 1); end
      checks++; if (CtrlState !== 3'd0) begin errors++; $display("FAIL step_state[%0d]: got %0d want 0", k, CtrlState); end
      tick();
      checks++; if (ProcEn !== 1'b0) begin errors++; $display("FAIL step_en_off[%0d]: got %b want 0", k, ProcEn); end
      repeat (3) tick();
    end
    checks++; if (EnCount !== 16'd3) begin errors++; $display("FAIL step_total: got %0d want 3", EnCount); end
  endtask

  task automatic test_step_instr;
    model_init(7'h0);
    StepMode = 1'b1;
    StepPulse = 1'b1;
    tick();
    StepPulse = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      checks++; if (ProcEn !== ((i % 2 == 1) && i <= 7)) begin errors++; $display("FAIL instr_en[%0d]: got %b want %b", i, ProcEn, (i % 2 == 1) && i <= 7); end
      checks++; if (Running !== (i <= 8)) begin errors++; $display("FAIL instr_running[%0d]: got %b want %b", i, Running, i <= 8); end
      tick();
    end
    checks++; if (CtrlState !== 3'd0) begin errors++; $display("FAIL instr_state: got %0d want 0", CtrlState); end
    checks++; if (EnCount !== 16'd7) begin errors++; $display("FAIL instr_cnt: got %0d want 7", EnCount); end
    checks++; if (ProcState !== 4'h1) begin errors++; $display("FAIL instr_procstate: got %h want 1", ProcState); end
  endtask

  task automatic test_abort;
    StepMode = 1'b1;
    StepPulse = 1'b1;
    tick();
    StepPulse = 1'b0;
    RunToggle = 1'b1;
    tick();
    RunToggle = 1'b0;
    checks++; if (CtrlState !== 3'd2 || ProcEn !== 1'b0) begin errors++; $display("FAIL abort_chk: state=%0d en=%b want 2/0", CtrlState, ProcEn); end
    tick();
    checks++; if (CtrlState !== 3'd0 || ProcEn !== 1'b0) begin errors++; $display("FAIL abort_idle: state=%0d en=%b want 0/0", CtrlState, ProcEn); end
    tick();
    checks++; if (EnCount !== 16'd8) begin errors++; $display("FAIL abort_cnt: got %0d want 8", EnCount); end
  endtask

  task automatic test_run;
    RunToggle = 1'b1;
    tick();
    RunToggle = 1'b0;
    checks++; if (CtrlState !== 3'd3 || Running !== 1'b1) begin errors++; $display("FAIL run_enter: state=%0d running=%b want 3/1", CtrlState, Running); end
    for (int i = 2; i <= 16; i++) begin
      tick();
      checks++; if (ProcEn !== (i == 5 || i == 9 || i == 13)) begin errors++; $display("FAIL run_en[%0d]: got %b want %b", i, ProcEn, i == 5 || i == 9 || i == 13); end
    end
    RunToggle = 1'b1;
    tick();
    RunToggle = 1'b0;
    checks++; if (ProcEn !== 1'b0) begin errors++; $display("FAIL run_stop_en: got %b want 0", ProcEn); end
    checks++; if (CtrlState !== 3'd0 || Running !== 1'b0) begin errors++; $display("FAIL run_stop_state: state=%0d running=%b want 0/0", CtrlState, Running); end
    repeat (6) tick();
    checks++; if (EnCount !== 16'd11) begin errors++; $display("FAIL run_cnt: got %0d want 11", EnCount); end
  endtask

  task automatic test_simultaneous;
    StepMode = 1'b0;
    StepPulse = 1'b1;
    RunToggle = 1'b1;
    tick();
    StepPulse = 1'b0;
    RunToggle = 1'b0;
    checks++; if (CtrlState !== 3'd3 || ProcEn !== 1'b0) begin errors++; $display("FAIL simul_run: state=%0d en=%b want 3/0", CtrlState, ProcEn); end
    tick();
    checks++; if (ProcEn !== 1'b0) begin errors++; $display("FAIL simul_en: got %b want 0", ProcEn); end
    RunToggle = 1'b1;
    tick();
    RunToggle = 1'b0;
    checks++; if (CtrlState !== 3'd0 || EnCount !== 16'd11) begin errors++; $display("FAIL simul_exit: state=%0d cnt=%0d want 0/11", CtrlState, EnCount); end
  endtask

`ifdef PROC_BREAKPOINT_EN
  task automatic test_breakpoint;
    int n_en = 0;
    int n = 0;
    model_init(7'h3);
    BreakAddr = 7'h05;
    BreakArm = 1'b1;
    RunToggle = 1'b1;
    tick();
    RunToggle = 1'b0;
    while (Halted !== 1'b1 && n < 80) begin
      if (ProcEn === 1'b1) n_en++;
      tick();
      n++;
    end
    checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL brk_timeout: halted=%b want 1", Halted); end
    checks++; if (n_en != 8) begin errors++; $display("FAIL brk_enables: got %0d want 8", n_en); end
    checks++; if (CtrlState !== 3'd4 || Running !== 1'b0) begin errors++; $display("FAIL brk_state: state=%0d running=%b want 4/0", CtrlState, Running); end
    checks++; if (PC_In !== 7'h05 || ProcState !== 4'h1) begin errors++; $display("FAIL brk_pc: pc=%h ps=%h want 05/1", PC_In, ProcState); end
    checks++; if (EnCount !== 16'd19) begin errors++; $display("FAIL brk_cnt: got %0d want 19", EnCount); end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (ProcEn !== 1'b0 || Halted !== 1'b1) begin errors++; $display("FAIL brk_hold[%0d]: en=%b halted=%b want 0/1", i, ProcEn, Halted); end
    end
    RunToggle = 1'b1;
    tick();
    RunToggle = 1'b0;
    checks++; if (CtrlState !== 3'd3 || Halted !== 1'b0) begin errors++; $display("FAIL brk_resume: state=%0d halted=%b want 3/0", CtrlState, Halted); end
    repeat (4) tick();
    checks++; if (ProcEn !== 1'b1) begin errors++; $display("FAIL brk_first_en: got %b want 1", ProcEn); end
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++; if (Halted !== 1'b0 || CtrlState !== 3'd3) begin errors++; $display("FAIL brk_rehalt[%0d]: halted=%b state=%0d want 0/3", i, Halted, CtrlState); end
    end
    RunToggle = 1'b1;
    tick();
    RunToggle = 1'b0;
    BreakArm = 1'b0;
    checks++; if (CtrlState !== 3'd0) begin errors++; $display("FAIL brk_stop: got %0d want 0", CtrlState); end
  endtask
`else
  task automatic test_breakpoint;
    model_init(7'h5);
    BreakAddr = 7'h06;
    BreakArm = 1'b1;
    StepMode = 1'b1;
    StepPulse = 1'b1;
    tick();
    StepPulse = 1'b0;
    repeat (8) tick();
    checks++; if (CtrlState !== 3'd0 || Halted !== 1'b0) begin errors++; $display("FAIL nobrk_state: state=%0d halted=%b want 0/0", CtrlState, Halted); end
    checks++; if (PC_In !== 7'h06 || ProcState !== 4'h1) begin errors++; $display("FAIL nobrk_pc: pc=%h ps=%h want 06/1", PC_In, ProcState); end
    checks++; if (EnCount !== 16'd15) begin errors++; $display("FAIL nobrk_cnt: got %0d want 15", EnCount); end
    BreakArm = 1'b0;
  endtask
`endif

  task automatic test_async_reset;
    StepMode = 1'b1;
    StepPulse = 1'b1;
    tick();
    StepPulse = 1'b0;
    checks++; if (ProcEn !== 1'b1 || CtrlState !== 3'd1) begin errors++; $display("FAIL areset_pre: en=%b state=%0d want 1/1", ProcEn, CtrlState); end
    #2 Reset = 1'b0;
    #1;
    checks++; if (ProcEn !== 1'b0) begin errors++; $display("FAIL areset_en: got %b want 0", ProcEn); end
    checks++; if (EnCount !== 16'h0) begin errors++; $display("FAIL areset_cnt: got %h want 0000", EnCount); end
    checks++; if (CtrlState !== 3'd0 || Running !== 1'b0) begin errors++; $display("FAIL areset_state: state=%0d running=%b want 0/0", CtrlState, Running); end
    Reset = 1'b1;
    tick();
    checks++; if (CtrlState !== 3'd0 || ProcEn !== 1'b0) begin errors++; $display("FAIL areset_post: state=%0d en=%b want 0/0", CtrlState, ProcEn); end
  endtask

  initial begin
    test_reset();
    test_step_cycle();
    test_step_instr();
    test_abort();
    test_run();
    test_simultaneous();
    test_breakpoint();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
